// File: rtl/RS5_pkg.sv
// Shared vector-unit types: FSM states, LMUL encodings and register-group helpers.
// Reused by the ALU sequencer and the load/store unit.
package RS5_pkg;

  typedef enum logic [1:0] {
    V_IDLE = 2'd0,
    V_EXEC = 2'd1,
    V_END  = 2'd2
  } vector_states_e;

  // Encoding follows the vtype.vlmul field.
  typedef enum logic [2:0] {
    LMUL_1    = 3'b000,
    LMUL_2    = 3'b001,
    LMUL_4    = 3'b010,
    LMUL_8    = 3'b011,
    LMUL_RSVD = 3'b100,
    LMUL_1_8  = 3'b101,
    LMUL_1_4  = 3'b110,
    LMUL_1_2  = 3'b111
  } vlmul_e;

  // Fractional LMUL still occupies one whole register.
  function automatic logic [3:0] lmul_group_size(input vlmul_e vlmul);
    logic [3:0] n;
    n = 4'd1;
    case (vlmul)
      LMUL_2:  n = 4'd2;
      LMUL_4:  n = 4'd4;
      LMUL_8:  n = 4'd8;
      default: n = 4'd1;
    endcase
    return n;
  endfunction

  // Index of the final step for a group; widening doubles the step count.
  function automatic logic [3:0] lmul_last_step(input vlmul_e vlmul, input logic widening);
    logic [4:0] steps;
    steps = widening ? {lmul_group_size(vlmul), 1'b0} : {1'b0, lmul_group_size(vlmul)};
    return 4'(steps - 5'd1);
  endfunction

endpackage

// File: rtl/vector_exec_sequencer.sv
// Issue-side sequencer for the vector ALU: walks the LMUL register group one
// step per cycle, honours ALU hold and VRF stall, and emits registered write strobes.
module vector_exec_sequencer
  import RS5_pkg::*;
#(
  parameter int VLEN      = 64,
  parameter int MAX_GROUP = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  vlmul_e                   vlmul_i,
  input  logic [$bits(VLEN)-1:0]   vl_i,
  input  logic                     widening_i,
  input  logic                     reduction_i,
  input  logic                     alu_hold_i,
  input  logic                     stall_i,
  output vector_states_e           current_state_o,
  output logic [3:0]               cycle_count_o,
  output logic [3:0]               cycle_count_r_o,
  output logic                     widen_hi_o,
  output logic                     write_enable_o,
  output logic [3:0]               write_offset_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int STEP_W = $clog2(2 * MAX_GROUP);

  vector_states_e      state;
  logic [STEP_W-1:0]   step;
  logic [STEP_W-1:0]   last_step;
  logic                widening;
  logic                reduction;
  logic                advance;
  logic                final_step;

  assign advance    = (state == V_EXEC) && !alu_hold_i && !stall_i;
  assign final_step = (step == last_step);

  // State and step counter; captured fields are dropped on the way back to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= V_IDLE;
      step      <= '0;
      last_step <= '0;
      widening  <= 1'b0;
      reduction <= 1'b0;
    end else begin
      case (state)
        V_IDLE: begin
          if (start_i) begin
            if (vl_i != '0) begin
              state     <= V_EXEC;
              step      <= '0;
              last_step <= STEP_W'(lmul_last_step(vlmul_i, widening_i));
              widening  <= widening_i;
              reduction <= reduction_i;
            end else begin
              state <= V_END;
            end
          end
        end
        V_EXEC: begin
          if (advance) begin
            if (final_step) begin
              state <= V_END;
            end else begin
              step <= step + 1'b1;
            end
          end
        end
        V_END: begin
          state     <= V_IDLE;
          step      <= '0;
          last_step <= '0;
          widening  <= 1'b0;
          reduction <= 1'b0;
        end
        default: begin
          state <= V_IDLE;
        end
      endcase
    end
  end

  // The ALU result demux is registered, so the strobe lags the advancing step by one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_enable_o <= 1'b0;
      write_offset_o <= '0;
    end else begin
      write_enable_o <= advance && (!reduction || final_step);
      if (advance) begin
        write_offset_o <= reduction ? 4'd0 : 4'(step);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count_r_o <= '0;
    end else begin
      cycle_count_r_o <= cycle_count_o;
    end
  end

  assign current_state_o = state;
  assign cycle_count_o   = widening ? 4'(step >> 1) : 4'(step);
  assign widen_hi_o      = widening & step[0];
  assign busy_o          = (state != V_IDLE);
  assign done_o          = (state == V_END);

endmodule

// File: tb/tb_vector_exec_sequencer.sv
// Randomised and directed bench for vector_exec_sequencer against a cycle model
// built from the group-walk rules, plus per-instruction write-count checks.
module tb_vector_exec_sequencer;
  import RS5_pkg::*;

  localparam int BUDGET = 200;

  logic           clk;
  logic           reset;
  logic           start;
  vlmul_e         vlmul;
  logic [31:0]    vl;
  logic           widening;
  logic           reduction;
  logic           alu_hold;
  logic           stall;
  vector_states_e current_state;
  logic [3:0]     cycle_count;
  logic [3:0]     cycle_count_r;
  logic           widen_hi;
  logic           write_enable;
  logic [3:0]     write_offset;
  logic           busy;
  logic           done;

  vector_exec_sequencer #(.VLEN(64), .MAX_GROUP(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start),
    .vlmul_i         (vlmul),
    .vl_i            (vl),
    .widening_i      (widening),
    .reduction_i     (reduction),
    .alu_hold_i      (alu_hold),
    .stall_i         (stall),
    .current_state_o (current_state),
    .cycle_count_o   (cycle_count),
    .cycle_count_r_o (cycle_count_r),
    .widen_hi_o      (widen_hi),
    .write_enable_o  (write_enable),
    .write_offset_o  (write_offset),
    .busy_o          (busy),
    .done_o          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 executing, 2 end. Step is the position within the group walk.
  int m_state, m_step, m_steps, m_wid, m_red, m_cc_r, m_we, m_off;

  function automatic int group_of(input vlmul_e m);
    case (m)
      LMUL_2:  return 2;
      LMUL_4:  return 4;
      LMUL_8:  return 8;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_step = 0; m_steps = 0; m_wid = 0; m_red = 0;
    m_cc_r = 0; m_we = 0; m_off = 0;
  endtask

  // Predict the outputs after the next rising edge from the inputs now being driven.
  task automatic model_step();
    int adv;
    m_cc_r = m_wid ? m_step / 2 : m_step;
    adv = (m_state == 1) && !alu_hold && !stall;
    m_we = adv && (!m_red || m_step == m_steps - 1);
    if (adv) m_off = m_red ? 0 : m_step;
    if (m_state == 0) begin
      if (start) begin
        if (vl != 0) begin
          m_state = 1; m_step = 0; m_wid = widening; m_red = reduction;
          m_steps = (widening ? 2 : 1) * group_of(vlmul);
        end else begin
          m_state = 2;
        end
      end
    end else if (m_state == 1) begin
      if (adv) begin
        if (m_step == m_steps - 1) m_state = 2;
        else m_step = m_step + 1;
      end
    end else begin
      m_state = 0; m_step = 0; m_wid = 0; m_red = 0; m_steps = 0;
    end
  endtask

  function automatic int exp_state_code();
    if (m_state == 1) return int'(V_EXEC);
    if (m_state == 2) return int'(V_END);
    return int'(V_IDLE);
  endfunction

  always @(negedge clk) begin
    chk("state", int'(current_state), exp_state_code());
    chk("cycle_count", int'(cycle_count), m_wid ? m_step / 2 : m_step);
    chk("cycle_count_r", int'(cycle_count_r), m_cc_r);
    chk("widen_hi", int'(widen_hi), m_wid & (m_step % 2));
    chk("write_enable", int'(write_enable), m_we);
    if (m_we != 0) chk("write_offset", int'(write_offset), m_off);
    chk("busy", int'(busy), (m_state != 0) ? 1 : 0);
    chk("done", int'(done), (m_state == 2) ? 1 : 0);
  end

  bit     hold_sched  [0:BUDGET-1];
  bit     stall_sched [0:BUDGET-1];
  int     obs_cc      [0:BUDGET];
  int     obs_whi     [0:BUDGET];
  int     obs_off     [0:BUDGET];
  int     max_cc_r;
  int     we_j;
  vlmul_e lm_tab      [0:6];

  task automatic clear_sched();
    for (int i = 0; i < BUDGET; i++) begin
      hold_sched[i] = 1'b0;
      stall_sched[i] = 1'b0;
    end
  endtask

  task automatic random_sched();
    for (int i = 0; i < BUDGET; i++) begin
      hold_sched[i]  = ($urandom_range(0, 9) < 3);
      stall_sched[i] = ($urandom_range(0, 9) < 2);
    end
  endtask

  task automatic idle_cycle();
    start = 1'b0;
    vlmul = lm_tab[$urandom_range(0, 6)];
    vl = $urandom;
    widening = 1'($urandom_range(0, 1));
    reduction = 1'($urandom_range(0, 1));
    alu_hold = 1'($urandom_range(0, 1));
    stall = 1'($urandom_range(0, 1));
    model_step();
    @(negedge clk);
    #1;
  endtask

  // Runs one instruction starting at negedge+1; returns the observation index of done and the write count.
  task automatic run_instr(input vlmul_e lm, input int vlen, input bit wid, input bit red,
                           input bit spurious, input int abort_j,
                           output int done_j, output int nwr);
    int exp_off, exp_wr;
    done_j = -1; nwr = 0; exp_off = 0; max_cc_r = 0; we_j = -1;
    for (int k = 0; k < BUDGET; k++) begin
      if (k == 0) begin
        start = 1'b1; vlmul = lm; vl = vlen; widening = wid; reduction = red;
      end else begin
        start = spurious && (m_state == 1) && (k == 1 || $urandom_range(0, 3) == 0);
        vlmul = lm_tab[$urandom_range(0, 6)];
        vl = $urandom_range(0, 40);
        widening = 1'($urandom_range(0, 1));
        reduction = 1'($urandom_range(0, 1));
      end
      alu_hold = hold_sched[k];
      stall = stall_sched[k];
      model_step();
      @(negedge clk);
      obs_cc[k+1]  = int'(cycle_count);
      obs_whi[k+1] = int'(widen_hi);
      if (int'(cycle_count_r) > max_cc_r) max_cc_r = int'(cycle_count_r);
      if (write_enable) begin
        obs_off[nwr] = int'(write_offset);
        nwr++;
        we_j = k + 1;
        chk("write_order", int'(write_offset), red ? 0 : exp_off);
        exp_off++;
      end
      if (done) done_j = k + 1;
      #1;
      if (k + 1 == abort_j) begin
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_rst_state", int'(current_state), int'(V_IDLE));
        chk("async_rst_cc", int'(cycle_count), 0);
        chk("async_rst_cc_r", int'(cycle_count_r), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_we", int'(write_enable), 0);
        chk("async_rst_off", int'(write_offset), 0);
        chk("async_rst_whi", int'(widen_hi), 0);
        start = 1'b0; alu_hold = 1'b0; stall = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        return;
      end
      if (done_j >= 0) break;
    end
    if (done_j < 0) begin
      chk("done_timeout", 0, 1);
    end else begin
      idle_cycle();
      exp_wr = (vlen == 0) ? 0 : (red ? 1 : (wid ? 2 : 1) * group_of(lm));
      chk("write_count", nwr, exp_wr);
    end
  endtask

  initial begin
    int dj, nw;
    vlmul_e lm;
    bit wid, red;
    int vlen;

    lm_tab[0] = LMUL_1_8; lm_tab[1] = LMUL_1_4; lm_tab[2] = LMUL_1_2; lm_tab[3] = LMUL_1;
    lm_tab[4] = LMUL_2;   lm_tab[5] = LMUL_4;   lm_tab[6] = LMUL_8;
    reset = 1'b1; start = 1'b0; vlmul = LMUL_1; vl = '0; widening = 1'b0; reduction = 1'b0;
    alu_hold = 1'b0; stall = 1'b0;
    model_reset();
    clear_sched();
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    idle_cycle();

    // LMUL_4 plain walk
    clear_sched();
    run_instr(LMUL_4, 16, 1'b0, 1'b0, 1'b0, -1, dj, nw);
    chk("t1_done_cycle", dj, 5);
    for (int i = 0; i < 4; i++) chk("t1_cc_seq", obs_cc[i+1], i);
    for (int i = 0; i < 4; i++) chk("t1_off_seq", obs_off[i], i);
    chk("t1_writes", nw, 4);

    // LMUL_2 widening
    run_instr(LMUL_2, 8, 1'b1, 1'b0, 1'b0, -1, dj, nw);
    chk("t2_cc_1", obs_cc[1], 0); chk("t2_cc_2", obs_cc[2], 0);
    chk("t2_cc_3", obs_cc[3], 1); chk("t2_cc_4", obs_cc[4], 1);
    chk("t2_whi_1", obs_whi[1], 0); chk("t2_whi_2", obs_whi[2], 1);
    chk("t2_whi_3", obs_whi[3], 0); chk("t2_whi_4", obs_whi[4], 1);
    for (int i = 0; i < 4; i++) chk("t2_off_seq", obs_off[i], i);

    // LMUL_8 reduction
    run_instr(LMUL_8, 64, 1'b0, 1'b1, 1'b0, -1, dj, nw);
    chk("t3_max_cc_r", max_cc_r, 7);
    chk("t3_writes", nw, 1);
    chk("t3_off", obs_off[0], 0);
    chk("t3_we_with_done", we_j, dj);

    // LMUL_2 with hold then stall at step 1
    clear_sched();
    hold_sched[2] = 1'b1; hold_sched[3] = 1'b1; hold_sched[4] = 1'b1;
    stall_sched[5] = 1'b1; stall_sched[6] = 1'b1;
    run_instr(LMUL_2, 4, 1'b0, 1'b0, 1'b0, -1, dj, nw);
    chk("t4_done_cycle", dj, 8);
    chk("t4_writes", nw, 2);
    clear_sched();

    // vl == 0
    run_instr(LMUL_4, 0, 1'b0, 1'b0, 1'b0, -1, dj, nw);
    chk("t5_done_cycle", dj, 1);
    chk("t5_writes", nw, 0);

    // reset at step 2 with a start pulsed while busy, then a clean rerun
    run_instr(LMUL_4, 16, 1'b0, 1'b0, 1'b1, 3, dj, nw);
    chk("t6_cc_at_abort", obs_cc[3], 2);
    run_instr(LMUL_4, 16, 1'b0, 1'b0, 1'b0, -1, dj, nw);
    chk("t6_rerun_done", dj, 5);
    for (int i = 0; i < 4; i++) chk("t6_rerun_cc", obs_cc[i+1], i);

    // randomised traffic
    for (int n = 0; n < 150; n++) begin
      lm = lm_tab[$urandom_range(0, 6)];
      wid = (lm == LMUL_8) ? 1'b0 : 1'($urandom_range(0, 1));
      red = ($urandom_range(0, 3) == 0);
      vlen = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 64));
      random_sched();
      run_instr(lm, vlen, wid, red, 1'b1, -1, dj, nw);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
